// File: rtl/cvmcu_dbg_halt_pkg.sv
// Shared types and constants for the multi-hart debug halt controller.
package cvmcu_dbg_halt_pkg;

    // Per-hart halt state, also exported on hart_state_o.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2,
        TOUT   = 2'd3
    } hart_state_e;

    localparam int DEF_NUM_HARTS   = 4;
    localparam int DEF_REQ_MIN_CYC = 3;
    localparam int DEF_TIMEOUT_CYC = 64;
    localparam int DEF_STOP_DLY    = 2;

    // Bits needed to hold 0..max_val; never less than one bit so a
    // zero-length delay still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/cvmcu_dbg_halt_ctrl_if.sv
// Bundle of the debug-module side and core side signals of the halt controller.
interface cvmcu_dbg_halt_ctrl_if #(
    parameter int NUM_HARTS = 4
);
    logic [NUM_HARTS-1:0]   dbg_req_i;
    logic [NUM_HARTS-1:0]   halted_i;
    logic                   clr_timeout_i;
    logic [NUM_HARTS-1:0]   debug_req_o;
    logic                   stoptimer_o;
    logic [NUM_HARTS-1:0]   timeout_o;
    logic [2*NUM_HARTS-1:0] hart_state_o;

    // Controller side.
    modport slave (
        input  dbg_req_i, halted_i, clr_timeout_i,
        output debug_req_o, stoptimer_o, timeout_o, hart_state_o
    );

    // Debug module / core side.
    modport master (
        output dbg_req_i, halted_i, clr_timeout_i,
        input  debug_req_o, stoptimer_o, timeout_o, hart_state_o
    );
endinterface

// File: rtl/cvmcu_dbg_hart_fsm.sv
// One hart's halt sequencer: request hold, halt-ack tracking and sticky timeout.
module cvmcu_dbg_hart_fsm
    import cvmcu_dbg_halt_pkg::*;
#(
    parameter int REQ_MIN_CYC = DEF_REQ_MIN_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dbg_req,
    input  logic        halted,
    input  logic        clr_timeout,
    output logic        debug_req,
    output logic        timeout,
    output hart_state_e state,
    output logic        halted_nxt
);
    localparam int CW = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] HOLD_LAST = CW'(REQ_MIN_CYC - 1);
    localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYC);

    hart_state_e   state_r;
    hart_state_e   state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          set_tout_s;
    logic          debug_req_r;
    logic          timeout_r;

    // Next-state decision; an ack is only honoured once the request has been held long enough.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        set_tout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (halted) begin
                    state_nxt_s = HALTED;
                end else if (dbg_req) begin
                    state_nxt_s = REQ;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (cnt_r == CNT_MAX) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1'b1);
                end
                if (halted && (cnt_r >= HOLD_LAST)) begin
                    state_nxt_s = HALTED;
                end else if (!halted && (cnt_r == TOUT_LAST)) begin
                    state_nxt_s = TOUT;
                    set_tout_s  = 1'b1;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            HALTED: begin
                if (!halted) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HALTED;
                end
            end
            TOUT: begin
                if (halted) begin
                    state_nxt_s = HALTED;
                end else if (!dbg_req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = TOUT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter, request and sticky timeout registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            debug_req_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            debug_req_r <= (state_nxt_s == REQ);
            if (set_tout_s) begin
                timeout_r <= 1'b1;
            end else if (clr_timeout) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign debug_req  = debug_req_r;
    assign timeout    = timeout_r;
    assign state      = state_r;
    // Look-ahead halted flag lets the stop timer assert in the same cycle as the state update.
    assign halted_nxt = (state_nxt_s == HALTED);

endmodule

// File: rtl/cvmcu_dbg_halt_ctrl.sv
// Multi-hart debug halt controller: per-hart sequencers plus aggregated stop-timer request.
module cvmcu_dbg_halt_ctrl
    import cvmcu_dbg_halt_pkg::*;
#(
    parameter int NUM_HARTS   = DEF_NUM_HARTS,
    parameter int REQ_MIN_CYC = DEF_REQ_MIN_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int STOP_DLY    = DEF_STOP_DLY
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cvmcu_dbg_halt_ctrl_if.slave  bus
);
    localparam int SW = cnt_width(STOP_DLY);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_DLY);

    logic [NUM_HARTS-1:0]   debug_req_s;
    logic [NUM_HARTS-1:0]   timeout_s;
    logic [NUM_HARTS-1:0]   halted_nxt_s;
    logic [2*NUM_HARTS-1:0] hart_state_s;
    logic                   any_halted_nxt_s;
    logic [SW-1:0]          stop_cnt_r;
    logic                   stoptimer_r;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        hart_state_e st_s;

        cvmcu_dbg_hart_fsm #(
            .REQ_MIN_CYC (REQ_MIN_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_fsm (
            .clk         (clk),
            .reset_n     (reset_n),
            .dbg_req     (bus.dbg_req_i[h]),
            .halted      (bus.halted_i[h]),
            .clr_timeout (bus.clr_timeout_i),
            .debug_req   (debug_req_s[h]),
            .timeout     (timeout_s[h]),
            .state       (st_s),
            .halted_nxt  (halted_nxt_s[h])
        );

        assign hart_state_s[2*h +: 2] = st_s;
    end

    assign any_halted_nxt_s = |halted_nxt_s;

    // Stop-timer delay: counts while any hart is halted, saturates at the delay, clears when none is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stop_cnt_r  <= {SW{1'b0}};
            stoptimer_r <= 1'b0;
        end else if (!any_halted_nxt_s) begin
            stop_cnt_r  <= {SW{1'b0}};
            stoptimer_r <= 1'b0;
        end else begin
            stoptimer_r <= (stop_cnt_r == STOP_LAST);
            if (stop_cnt_r != STOP_LAST) begin
                stop_cnt_r <= stop_cnt_r + SW'(1'b1);
            end else begin
                stop_cnt_r <= stop_cnt_r;
            end
        end
    end

    assign bus.debug_req_o  = debug_req_s;
    assign bus.timeout_o    = timeout_s;
    assign bus.hart_state_o = hart_state_s;
    assign bus.stoptimer_o  = stoptimer_r;

endmodule

// File: tb/tb_cvmcu_dbg_halt_ctrl.sv
// Scoreboard bench for cvmcu_dbg_halt_ctrl: directed vectors queue expected
// outputs tagged with a cycle number; a monitor compares them on the falling edge.
module tb_cvmcu_dbg_halt_ctrl;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    cvmcu_dbg_halt_ctrl_if #(.NUM_HARTS(4)) bus ();

    cvmcu_dbg_halt_ctrl #(
        .NUM_HARTS   (4),
        .REQ_MIN_CYC (3),
        .TIMEOUT_CYC (64),
        .STOP_DLY    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] dq;
        logic       sp;
        logic [3:0] to;
        logic [7:0] st;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    // Cycle stamp: cycle N begins at the Nth rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due in this cycle and compare.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if (e.cyc < cyc) begin
                miscompares++;
                $display("FAIL %s: expectation for cycle %0d was never sampled (now %0d)", e.name, e.cyc, cyc);
            end else if ({bus.debug_req_o, bus.stoptimer_o, bus.timeout_o, bus.hart_state_o}
                         !== {e.dq, e.sp, e.to, e.st}) begin
                miscompares++;
                $display("FAIL %s @%0d: got dreq=%b stop=%b tout=%b st=%h, want dreq=%b stop=%b tout=%b st=%h",
                         e.name, cyc, bus.debug_req_o, bus.stoptimer_o, bus.timeout_o, bus.hart_state_o,
                         e.dq, e.sp, e.to, e.st);
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int c, input string n, input logic [3:0] dq, input logic sp,
                            input logic [3:0] to, input logic [7:0] st);
        exp_t e;
        e.cyc = c; e.name = n; e.dq = dq; e.sp = sp; e.to = to; e.st = st;
        sb.push_back(e);
    endtask

    initial begin : stim
        int b;
        int guard;
        bus.dbg_req_i     = 4'b0000;
        bus.halted_i      = 4'b0000;
        bus.clr_timeout_i = 1'b0;
        #1 reset_n = 1'b0;

        // Reset, then idle.
        push_exp(2, "rst_hold_a", 4'h0, 1'b0, 4'h0, 8'h00);
        push_exp(4, "rst_hold_b", 4'h0, 1'b0, 4'h0, 8'h00);
        goto(5);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) push_exp(5 + 10 * k, "idle", 4'h0, 1'b0, 4'h0, 8'h00);
        goto(106);

        // Basic halt of hart 1, ignored re-request while halted, resume.
        b = cyc;
        push_exp(b + 10, "h1_pre",       4'h0, 1'b0, 4'h0, 8'h00);
        push_exp(b + 11, "h1_req_a",     4'h2, 1'b0, 4'h0, 8'h04);
        push_exp(b + 12, "h1_req_b",     4'h2, 1'b0, 4'h0, 8'h04);
        push_exp(b + 13, "h1_req_c",     4'h2, 1'b0, 4'h0, 8'h04);
        push_exp(b + 14, "h1_halted",    4'h0, 1'b0, 4'h0, 8'h08);
        push_exp(b + 15, "h1_stop_dly",  4'h0, 1'b0, 4'h0, 8'h08);
        push_exp(b + 16, "h1_stop_on",   4'h0, 1'b1, 4'h0, 8'h08);
        push_exp(b + 21, "h1_rereq_ign", 4'h0, 1'b1, 4'h0, 8'h08);
        push_exp(b + 30, "h1_still",     4'h0, 1'b1, 4'h0, 8'h08);
        push_exp(b + 31, "h1_resume",    4'h0, 1'b0, 4'h0, 8'h00);
        goto(b + 10); bus.dbg_req_i = 4'b0010;
        goto(b + 12); bus.halted_i  = 4'b0010;
        goto(b + 15); bus.dbg_req_i = 4'b0000;
        goto(b + 20); bus.dbg_req_i = 4'b0010;
        goto(b + 22); bus.dbg_req_i = 4'b0000;
        goto(b + 30); bus.halted_i  = 4'b0000;
        goto(b + 35);

        // Timeout on hart 0, clear, then late ack.
        b = cyc;
        push_exp(b + 1,  "t0_req_first", 4'h1, 1'b0, 4'h0, 8'h01);
        push_exp(b + 64, "t0_req_last",  4'h1, 1'b0, 4'h0, 8'h01);
        push_exp(b + 65, "t0_tout",      4'h0, 1'b0, 4'h1, 8'h03);
        push_exp(b + 70, "t0_sticky",    4'h0, 1'b0, 4'h1, 8'h03);
        push_exp(b + 71, "t0_cleared",   4'h0, 1'b0, 4'h0, 8'h03);
        push_exp(b + 76, "t0_late_ack",  4'h0, 1'b0, 4'h0, 8'h02);
        push_exp(b + 77, "t0_stop_dly",  4'h0, 1'b0, 4'h0, 8'h02);
        push_exp(b + 78, "t0_stop_on",   4'h0, 1'b1, 4'h0, 8'h02);
        push_exp(b + 81, "t0_idle",      4'h0, 1'b0, 4'h0, 8'h00);
        bus.dbg_req_i = 4'b0001;
        goto(b + 70); bus.clr_timeout_i = 1'b1;
        goto(b + 71); bus.clr_timeout_i = 1'b0;
        goto(b + 75); bus.halted_i = 4'b0001;
        goto(b + 80); bus.dbg_req_i = 4'b0000; bus.halted_i = 4'b0000;
        goto(b + 82);

        // Timeout on hart 2 coinciding with a clear pulse: set wins.
        b = cyc;
        push_exp(b + 64, "t2_req_last", 4'h4, 1'b0, 4'h0, 8'h10);
        push_exp(b + 65, "t2_set_wins", 4'h0, 1'b0, 4'h4, 8'h30);
        push_exp(b + 67, "t2_idle_stk", 4'h0, 1'b0, 4'h4, 8'h00);
        push_exp(b + 69, "t2_cleared",  4'h0, 1'b0, 4'h0, 8'h00);
        bus.dbg_req_i = 4'b0100;
        goto(b + 64); bus.clr_timeout_i = 1'b1;
        goto(b + 65); bus.clr_timeout_i = 1'b0;
        goto(b + 66); bus.dbg_req_i = 4'b0000;
        goto(b + 68); bus.clr_timeout_i = 1'b1;
        goto(b + 69); bus.clr_timeout_i = 1'b0;
        goto(b + 70);

        // Early ack on hart 2 (hold honoured); lost ack and dropped request on hart 1.
        b = cyc;
        push_exp(b + 1,  "ea_req_a",   4'h6, 1'b0, 4'h0, 8'h14);
        push_exp(b + 2,  "ea_req_b",   4'h6, 1'b0, 4'h0, 8'h14);
        push_exp(b + 3,  "ea_req_c",   4'h6, 1'b0, 4'h0, 8'h14);
        push_exp(b + 4,  "ea_h2_halt", 4'h2, 1'b0, 4'h0, 8'h24);
        push_exp(b + 5,  "ea_h1_lost", 4'h2, 1'b0, 4'h0, 8'h24);
        push_exp(b + 6,  "ea_stop_on", 4'h2, 1'b1, 4'h0, 8'h24);
        push_exp(b + 7,  "ea_h1_halt", 4'h0, 1'b1, 4'h0, 8'h28);
        push_exp(b + 11, "ea_idle",    4'h0, 1'b0, 4'h0, 8'h00);
        bus.dbg_req_i = 4'b0110;
        goto(b + 2);  bus.halted_i = 4'b0110;
        goto(b + 3);  bus.halted_i = 4'b0100; bus.dbg_req_i = 4'b0100;
        goto(b + 6);  bus.halted_i = 4'b0110;
        goto(b + 10); bus.halted_i = 4'b0000; bus.dbg_req_i = 4'b0000;
        goto(b + 12);

        // Overlapping self-halts of harts 0 and 3, then a same-cycle handoff 0 -> 1.
        b = cyc;
        push_exp(b + 19, "ov_pre",      4'h0, 1'b0, 4'h0, 8'h00);
        push_exp(b + 20, "ov_h0_halt",  4'h0, 1'b0, 4'h0, 8'h02);
        push_exp(b + 21, "ov_dly",      4'h0, 1'b0, 4'h0, 8'h02);
        push_exp(b + 22, "ov_stop_on",  4'h0, 1'b1, 4'h0, 8'h02);
        push_exp(b + 25, "ov_h3_halt",  4'h0, 1'b1, 4'h0, 8'h82);
        push_exp(b + 40, "ov_h0_res",   4'h0, 1'b1, 4'h0, 8'h80);
        push_exp(b + 50, "ov_h3_last",  4'h0, 1'b1, 4'h0, 8'h80);
        push_exp(b + 51, "ov_all_res",  4'h0, 1'b0, 4'h0, 8'h00);
        push_exp(b + 61, "ho_h0_halt",  4'h0, 1'b0, 4'h0, 8'h02);
        push_exp(b + 63, "ho_stop_on",  4'h0, 1'b1, 4'h0, 8'h02);
        push_exp(b + 70, "ho_before",   4'h0, 1'b1, 4'h0, 8'h02);
        push_exp(b + 71, "ho_handoff",  4'h0, 1'b1, 4'h0, 8'h08);
        push_exp(b + 72, "ho_no_rst",   4'h0, 1'b1, 4'h0, 8'h08);
        push_exp(b + 76, "ho_idle",     4'h0, 1'b0, 4'h0, 8'h00);
        goto(b + 19); bus.halted_i = 4'b0001;
        goto(b + 24); bus.halted_i = 4'b1001;
        goto(b + 39); bus.halted_i = 4'b1000;
        goto(b + 50); bus.halted_i = 4'b0000;
        goto(b + 60); bus.halted_i = 4'b0001;
        goto(b + 70); bus.halted_i = 4'b0010;
        goto(b + 75); bus.halted_i = 4'b0000;
        goto(b + 78);

        // Reset asserted mid-request on hart 1 (cnt = 5); nothing is replayed.
        b = cyc;
        push_exp(b + 5,  "mr_req",      4'h2, 1'b0, 4'h0, 8'h04);
        push_exp(b + 6,  "mr_async",    4'h0, 1'b0, 4'h0, 8'h00);
        push_exp(b + 8,  "mr_in_rst",   4'h0, 1'b0, 4'h0, 8'h00);
        push_exp(b + 12, "mr_after_a",  4'h0, 1'b0, 4'h0, 8'h00);
        push_exp(b + 20, "mr_after_b",  4'h0, 1'b0, 4'h0, 8'h00);
        bus.dbg_req_i = 4'b0010;
        goto(b + 6); #2 reset_n = 1'b0;
        goto(b + 7); bus.dbg_req_i = 4'b0000;
        goto(b + 9); reset_n = 1'b1;
        goto(b + 21);

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation for cycle %0d still pending at end", e.name, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cvmcu_dbg_halt_ctrl.md
Name: cvmcu_dbg_halt_ctrl

Overview:
- Multi-hart debug halt controller placed between the debug module and NUM_HARTS core debug ports.
- Generalises the single-hart debug_req_i / stoptimer_o loop to N harts.
- Per hart it adds a minimum request-hold time, halt-acknowledge tracking and a sticky timeout.
- Produces one aggregated stoptimer_o with programmable assert delay; used both in the MCU debug path and in the dbg agent self-test bench.

Parameters:
- NUM_HARTS, 4: number of harts/channels (1..16).
- REQ_MIN_CYC, 3: minimum cycles debug_req_o stays high once raised (>=1).
- TIMEOUT_CYC, 64: cycles in REQ without halt before timeout (> REQ_MIN_CYC).
- STOP_DLY, 2: cycles from first hart entering HALTED to stoptimer_o high (0 = same cycle as state update).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dbg_req_i  in  NUM_HARTS  level halt request per hart from debug module
- halted_i  in  NUM_HARTS  per-hart core status, high while in debug mode
- clr_timeout_i  in  1  single-cycle pulse, clears all timeout_o bits
- debug_req_o  out  NUM_HARTS  registered debug request to each core
- stoptimer_o  out  1  registered stop-timer request to system timers
- timeout_o  out  NUM_HARTS  sticky: request not acknowledged within TIMEOUT_CYC
- hart_state_o  out  2*NUM_HARTS  per-hart FSM state, hart h in bits [2h+1:2h]

Behaviour:
- Reset is asynchronous, active-low, applied to all flops.
- Reset values: debug_req_o=0, stoptimer_o=0, timeout_o=0, every hart_state_o=IDLE, all counters 0.
- Reset mid-operation aborts any REQ immediately; no request is replayed after reset.
- Per-hart FSM, encoded IDLE=0, REQ=1, HALTED=2, TOUT=3:
  - IDLE: halted_i=1 -> HALTED (self-halt, e.g. ebreak), taking priority over dbg_req_i. Else dbg_req_i=1 -> REQ, with cnt=0.
  - REQ: debug_req_o=1 and cnt increments each cycle.
    - halted_i=1 and cnt>=REQ_MIN_CYC-1 -> HALTED.
    - halted_i=1 earlier: stay in REQ until the hold is met; halted_i is sampled each cycle, so an ack that drops before the hold is met is lost.
    - cnt==TIMEOUT_CYC-1 with halted_i=0 -> TOUT, and timeout_o[h] is set.
    - dbg_req_i dropping while in REQ does not abort the request.
  - HALTED: debug_req_o=0. halted_i=0 -> IDLE. A new dbg_req_i while HALTED is ignored.
  - TOUT: debug_req_o=0. halted_i=1 -> HALTED (late ack); else dbg_req_i=0 -> IDLE.
- Output timing:
  - debug_req_o[h] is registered: it rises the cycle after dbg_req_i is sampled in IDLE and falls the cycle after the REQ exit.
  - Total debug_req_o width is max(REQ_MIN_CYC, ack latency) cycles.
- Timeout flags:
  - timeout_o[h] stays set until clr_timeout_i.
  - If clr_timeout_i and a new timeout occur in the same cycle, set wins.
- Stop timer:
  - any_halted = OR over harts of (state==HALTED).
  - A delay counter runs while any_halted=1; stoptimer_o asserts when it reaches STOP_DLY.
  - any_halted=0 clears the counter, and stoptimer_o deasserts on the next edge.
  - A hart handoff (one leaves HALTED as another enters in the same cycle) keeps any_halted=1, so no glitch and no restart.
- Counter widths: cnt is $clog2(TIMEOUT_CYC+1) bits and saturates (no wrap). The stop counter is $clog2(STOP_DLY+1) bits.
- Harts are fully independent; there are no cross-hart ordering constraints.

Decomposition:
- Package cvmcu_dbg_halt_pkg:
  - hart_state_e enum (IDLE, REQ, HALTED, TOUT, 2 bits).
  - Default parameter constants.
  - Helper function for counter width.
- Sub-module cvmcu_dbg_hart_fsm: one per hart, generated NUM_HARTS times. It holds the FSM, cnt, debug_req_o bit, timeout bit and the halted-state flag.
- The top holds the stoptimer aggregation and delay counter.

Test Plan:
1. Reset then idle: reset_n low for 5 cycles, then high with all inputs 0 -> all outputs 0 and hart_state_o=0 for 100 cycles.
2. Basic halt (defaults): dbg_req_i[1]=1 at cycle 10, halted_i[1] rises at cycle 12.
   - debug_req_o[1] high cycles 11..13.
   - hart1 HALTED at 14.
   - stoptimer_o high at 16.
   - Drop halted_i[1] at 30 -> IDLE at 31, stoptimer_o low at 31.
3. Timeout: dbg_req_i[0]=1, halted_i held 0 -> debug_req_o[0] high for exactly 64 cycles, then timeout_o[0]=1 and state TOUT.
   - clr_timeout_i pulse -> timeout_o[0]=0 next cycle.
   - Late halted_i[0]=1 -> HALTED.
4. Early ack / hold: halted_i[2] rises 1 cycle after debug_req_o[2] rises and stays high -> debug_req_o[2] still high for 3 cycles, then HALTED.
5. Multi-hart overlap: hart0 halts at cycle 20, hart3 halts at 25, hart0 resumes at 40, hart3 resumes at 50.
   - stoptimer_o high continuously from 22 to 50, low at 51.
   - Self-halt of hart3 with no request also drives HALTED.
6. Reset mid-REQ: assert reset_n=0 while hart1 is in REQ at cnt=5 -> debug_req_o[1] drops asynchronously, state returns to IDLE, and no request is re-issued after reset.
